uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the UART transmitter between both commit lanes of the superscalar core.
//  Accepts up to two MMIO byte stores per cycle, with lane 0 the older of the two.
//  Queues the bytes in program order in a FIFO and serializes them onto uart_tx as 8N1 frames.
//  Sits between the store-commit stage and the cpu's uart_tx pin.
// PARAMETERS
//  DEPTH    16   FIFO entries; power of 2, >= 2
//  CLK_DIV  868  sysclk cycles per serial bit (100 MHz / 115200 baud); >= 2
// PORTS
//  sysclk      in   1                 system clock; all state updates on rising edge
//  cpu_resetn  in   1                 asynchronous, active-low reset
//  wr0_valid   in   1                 lane 0 (older) byte store valid
//  wr0_data    in   8                 lane 0 byte
//  wr0_ready   out  1                 lane 0 accepted when valid & ready
//  wr1_valid   in   1                 lane 1 (younger) byte store valid
//  wr1_data    in   8                 lane 1 byte
//  wr1_ready   out  1                 lane 1 accepted when valid & ready
//  uart_tx     out  1                 serial line, idle high
//  busy        out  1                 frame in progress or FIFO non-empty
//  fifo_count  out  $clog2(DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset (async, cpu_resetn=0), effective immediately:
//  - uart_tx=1, busy=0, fifo_count=0, FSM=IDLE; pointers, bit counter and divider cleared.
//  - wr0_ready=1 and wr1_ready=1 once reset is applied.
//  - Reset mid-frame aborts the frame: line returns high at once, queued bytes discarded.
//  Ready rules:
//  - Both readys come only from registered fifo_count: wr0_ready = (count <= DEPTH-1), wr1_ready = (count <= DEPTH-2).
//  - Readys do not depend on valid, and do not credit a same-cycle pop.
//  Push:
//  - acc0 = wr0_valid & wr0_ready; acc1 = wr1_valid & wr1_ready.
//  - Both accepted: lane 0 byte written at wr_ptr, lane 1 byte at wr_ptr+1.
//  - Lane 1 alone: written at wr_ptr.
//  - Pointers wrap modulo DEPTH.
//  - Dual write with count = DEPTH-1: lane 0 accepted, lane 1 stalls (wr1_ready=0).
//  Count:
//  - count_next = count + acc0 + acc1 - pop.
//  - Simultaneous push and pop in one cycle are both honoured.
//  - count never exceeds DEPTH and never goes below 0.
//  FSM IDLE -> START -> DATA -> STOP:
//  - IDLE: uart_tx=1. If count != 0, pop head into shift register and go to START.
//  - START: uart_tx=0 for CLK_DIV cycles.
//  - DATA: 8 bits, LSB first, CLK_DIV cycles each. A 3-bit counter selects the bit; shift right at each bit end.
//  - STOP: uart_tx=1 for CLK_DIV cycles. At the end, if count != 0, pop and go straight to START (no idle gap); else go to IDLE.
//  Timing:
//  - A byte pushed into an empty, idle block at edge N: pop at edge N+1, uart_tx falls after edge N+1.
//  - Each frame lasts exactly 10*CLK_DIV cycles.
//  - uart_tx is driven from a flop (glitch-free). Divider counts CLK_DIV-1 down to 0.
//  busy = (state != IDLE) | (count != 0); it is combinational from registered state.
// TESTING (bench uses DEPTH=4, CLK_DIV=4)
//  1. Hold reset, then release.
//     -> uart_tx=1, busy=0, fifo_count=0, wr0_ready=wr1_ready=1 throughout.
//  2. Lane 0 writes 0xA5 once.
//     -> uart_tx low 4 cycles from the cycle after the push, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles.
//     -> busy falls after 40 cycles.
//  3. Same cycle: lane 0 writes 0x41, lane 1 writes 0x42.
//     -> frames 0x41 then 0x42 back-to-back, 80 cycles total, no idle cycle between.
//  4. Stall the line mid-frame and fill the FIFO.
//     -> count=3: wr0_ready=1, wr1_ready=0; a dual write accepts lane 0 only.
//     -> count=4: both readys 0.
//  5. Stream 0x00..0x13 with random single/dual writes honouring readys.
//     -> all 20 bytes decoded in order; pointer wrap verified; count stays in 0..4.
//  6. Assert cpu_resetn=0 during data bit 3 with 2 bytes queued.
//     -> uart_tx=1 in the same timestep, count=0.
//     -> after release, the line stays idle until the next write.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter between the two store-commit lanes. Up to two
//   MMIO byte stores are accepted per cycle (lane 0 is older), queued in
//   program order and serialized onto uart_tx as 8N1 frames.
//
// Ports
//   sysclk      in   system clock, all state updates on rising edge
//   cpu_resetn  in   asynchronous active-low reset
//   wr0_valid   in   lane 0 (older) byte store valid
//   wr0_data    in   lane 0 byte
//   wr0_ready   out  lane 0 accepted when valid & ready
//   wr1_valid   in   lane 1 (younger) byte store valid
//   wr1_data    in   lane 1 byte
//   wr1_ready   out  lane 1 accepted when valid & ready
//   uart_tx     out  serial line, idle high
//   busy        out  frame in progress or FIFO non-empty
//   fifo_count  out  current FIFO occupancy
module uart_tx_scheduler #(
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 868
) (
    input  logic                   sysclk,
    input  logic                   cpu_resetn,
    input  logic                   wr0_valid,
    input  logic [7:0]             wr0_data,
    output logic                   wr0_ready,
    input  logic                   wr1_valid,
    input  logic [7:0]             wr1_data,
    output logic                   wr1_ready,
    output logic                   uart_tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    state_t        state_reg;
    logic [DW-1:0] div_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;

    logic          acc0;
    logic          acc1;
    logic          pop;
    logic          div_done;
    logic [AW-1:0] wr1_idx;

    // Readys look only at the registered occupancy; a pop in the same cycle
    // is deliberately not credited so the ready path stays short.
    assign wr0_ready = (count_reg <= CW'(DEPTH - 1));
    assign wr1_ready = (count_reg <= CW'(DEPTH - 2));

    assign acc0 = wr0_valid & wr0_ready;
    assign acc1 = wr1_valid & wr1_ready;

    // Lane 1 lands behind lane 0 when both are accepted, otherwise at wr_ptr.
    assign wr1_idx = wr_ptr_reg + AW'(acc0);

    assign div_done = (div_reg == '0);

    // Head is popped either from IDLE or at the very end of a stop bit, so
    // queued bytes go out back-to-back without an idle gap.
    assign pop = (count_reg != '0) &&
                 ((state_reg == IDLE) || ((state_reg == STOP) && div_done));

    // Storage: no reset needed, occupancy alone tells which entries are live.
    always_ff @(posedge sysclk) begin
        if (acc0) begin
            mem[wr_ptr_reg] <= wr0_data;
        end
        if (acc1) begin
            mem[wr1_idx] <= wr1_data;
        end
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(acc0) + AW'(acc1);
            rd_ptr_reg <= rd_ptr_reg + AW'(pop);
            count_reg  <= count_reg + CW'(acc0) + CW'(acc1) - CW'(pop);
        end
    end

    // Frame sequencer. The line level is a flop so uart_tx never glitches.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        div_reg   <= DW'(CLK_DIV - 1);
                        tx_reg    <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (div_done) begin
                        div_reg   <= DW'(CLK_DIV - 1);
                        bit_reg   <= '0;
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end else begin
                        div_reg <= div_reg - 1'b1;
                    end
                end
                DATA: begin
                    if (div_done) begin
                        div_reg <= DW'(CLK_DIV - 1);
                        if (bit_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_reg   <= bit_reg + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx_reg    <= shift_reg[1];
                        end
                    end else begin
                        div_reg <= div_reg - 1'b1;
                    end
                end
                STOP: begin
                    if (div_done) begin
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            div_reg   <= DW'(CLK_DIV - 1);
                            tx_reg    <= 1'b0;
                            state_reg <= START;
                        end else begin
                            tx_reg    <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        div_reg <= div_reg - 1'b1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign uart_tx    = tx_reg;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE) | (count_reg != '0);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler (DEPTH=4, CLK_DIV=4). A queue-based model
// predicts occupancy, readys, busy and the serial line every cycle; a small
// UART receiver decodes frames; directed sections pin literal expectations.
module tb_uart_tx_scheduler;

    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       sysclk = 1'b0;
    logic       cpu_resetn = 1'b0;
    logic       wr0_valid = 1'b0;
    logic [7:0] wr0_data = 8'h00;
    logic       wr0_ready;
    logic       wr1_valid = 1'b0;
    logic [7:0] wr1_data = 8'h00;
    logic       wr1_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_scheduler #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .wr0_valid  (wr0_valid),
        .wr0_data   (wr0_data),
        .wr0_ready  (wr0_ready),
        .wr1_valid  (wr1_valid),
        .wr1_data   (wr1_data),
        .wr1_ready  (wr1_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    int         m_edge  = 0;
    int         m_start = 0;
    bit         m_act   = 1'b0;
    logic [7:0] m_cur   = 8'h00;

    function automatic logic frame_bit(input logic [7:0] b, input int off);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[off / CLK_DIV];
    endfunction

    always @(posedge sysclk or negedge cpu_resetn) begin
        int sz;
        bit a0;
        bit a1;
        if (!cpu_resetn) begin
            mq.delete();
            m_act  = 1'b0;
            m_edge = 0;
        end else begin
            m_edge++;
            sz = mq.size();
            a0 = wr0_valid && (sz <= DEPTH - 1);
            a1 = wr1_valid && (sz <= DEPTH - 2);
            if (m_act && (m_edge - m_start == FRAME)) m_act = 1'b0;
            if (!m_act && sz > 0) begin
                m_cur   = mq.pop_front();
                m_act   = 1'b1;
                m_start = m_edge;
            end
            if (a0) mq.push_back(wr0_data);
            if (a1) mq.push_back(wr1_data);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge sysclk) begin
        int cnt;
        cnt = mq.size();
        chk("line", uart_tx, m_act ? frame_bit(m_cur, m_edge - m_start) : 1'b1);
        chk("busy", busy, int'(m_act || cnt != 0));
        chk("fifo_count", fifo_count, cnt);
        chk("wr0_ready", wr0_ready, int'(cnt <= DEPTH - 1));
        chk("wr1_ready", wr1_ready, int'(cnt <= DEPTH - 2));
        chk("count_range", int'(fifo_count <= DEPTH), 1);
    end

    // ---------------- line receiver ----------------
    logic       rx_prev = 1'b1;
    bit         rx_on   = 1'b0;
    int         rx_off  = 0;
    logic [7:0] rx_sh   = 8'h00;
    logic [7:0] dq[$];

    always @(negedge sysclk) begin
        if (!cpu_resetn) begin
            rx_on   = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_on) begin
                if (rx_prev && !uart_tx) begin
                    rx_on  = 1'b1;
                    rx_off = 0;
                end
            end else begin
                rx_off++;
                if ((rx_off % CLK_DIV == CLK_DIV / 2) && rx_off > CLK_DIV && rx_off < 9 * CLK_DIV)
                    rx_sh = {uart_tx, rx_sh[7:1]};
                if (rx_off == FRAME - CLK_DIV / 2) begin
                    chk("rx_stop", uart_tx, 1);
                    chk("rx_byte", rx_sh, m_cur);
                    dq.push_back(rx_sh);
                    $display("rx byte 0x%02h at t=%0t", rx_sh, $time);
                    rx_on = 1'b0;
                end
            end
            rx_prev = uart_tx;
        end
    end

    // ---------------- directed / random stimulus ----------------
    task automatic wait_idle(input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            @(negedge sysclk);
            i++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    logic [9:0] pat_a;
    logic [9:0] pat_b;
    logic [7:0] exp4 [5];
    int         n;
    int         r;

    initial begin
        // 1. reset hold and release
        repeat (3) begin
            @(negedge sysclk);
            chk("rst_tx", uart_tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_rdy0", wr0_ready, 1);
            chk("rst_rdy1", wr1_ready, 1);
        end
        #1 cpu_resetn = 1'b1;
        repeat (3) begin
            @(negedge sysclk);
            chk("post_rst_tx", uart_tx, 1);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_rdy", {wr0_ready, wr1_ready}, 3);
        end

        // 2. single byte 0xA5
        dq.delete();
        wr0_valid = 1'b1; wr0_data = 8'hA5;
        @(negedge sysclk);
        wr0_valid = 1'b0;
        chk("t2_tx_before_pop", uart_tx, 1);
        chk("t2_busy_pushed", busy, 1);
        chk("t2_count_pushed", fifo_count, 1);
        pat_a = 10'b1_1010_0101_0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge sysclk);
            chk("t2_line", uart_tx, pat_a[k / CLK_DIV]);
        end
        chk("t2_busy_last", busy, 1);
        @(negedge sysclk);
        chk("t2_busy_fall", busy, 0);
        chk("t2_tx_idle", uart_tx, 1);
        chk("t2_rx_count", dq.size(), 1);

        // 3. dual write, back-to-back frames
        @(negedge sysclk);
        wr0_valid = 1'b1; wr0_data = 8'h41;
        wr1_valid = 1'b1; wr1_data = 8'h42;
        @(negedge sysclk);
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        chk("t3_count", fifo_count, 2);
        pat_a = 10'b1_0100_0001_0;
        pat_b = 10'b1_0100_0010_0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge sysclk);
            if (k < FRAME) chk("t3_line0", uart_tx, pat_a[k / CLK_DIV]);
            else           chk("t3_line1", uart_tx, pat_b[(k - FRAME) / CLK_DIV]);
        end
        @(negedge sysclk);
        chk("t3_busy_fall", busy, 0);

        // 4. fill the FIFO while a frame is in flight
        dq.delete();
        wr0_valid = 1'b1; wr0_data = 8'h10;
        wr1_valid = 1'b1; wr1_data = 8'h11;
        @(negedge sysclk);
        wr0_data = 8'h12; wr1_data = 8'h13;
        @(negedge sysclk);
        chk("t4_count3", fifo_count, 3);
        chk("t4_rdy0_at3", wr0_ready, 1);
        chk("t4_rdy1_at3", wr1_ready, 0);
        wr0_data = 8'h14; wr1_data = 8'h15;
        @(negedge sysclk);
        chk("t4_count4", fifo_count, 4);
        chk("t4_rdy0_full", wr0_ready, 0);
        chk("t4_rdy1_full", wr1_ready, 0);
        wr0_data = 8'h16; wr1_valid = 1'b0;
        @(negedge sysclk);
        wr0_valid = 1'b0;
        chk("t4_full_reject", fifo_count, 4);
        wait_idle(400);
        exp4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        chk("t4_rx_count", dq.size(), 5);
        for (int i = 0; i < 5 && i < dq.size(); i++) chk("t4_rx_order", dq[i], exp4[i]);

        // 5. random stream 0x00..0x13
        dq.delete();
        n = 0;
        for (int cyc = 0; cyc < 3000 && n < 20; cyc++) begin
            @(negedge sysclk);
            wr0_valid = 1'b0; wr1_valid = 1'b0;
            r = $urandom_range(0, 5);
            if (r >= 4 && wr0_ready && wr1_ready && n <= 18) begin
                wr0_valid = 1'b1; wr0_data = 8'(n);
                wr1_valid = 1'b1; wr1_data = 8'(n + 1);
                n += 2;
            end else if (r == 3 && wr1_ready) begin
                wr1_valid = 1'b1; wr1_data = 8'(n);
                n++;
            end else if (r == 2 && wr0_ready) begin
                wr0_valid = 1'b1; wr0_data = 8'(n);
                n++;
            end
        end
        @(negedge sysclk);
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        chk("t5_all_sent", n, 20);
        wait_idle(2000);
        chk("t5_rx_count", dq.size(), 20);
        for (int i = 0; i < dq.size(); i++) chk("t5_rx_order", dq[i], i);

        // 6. reset during data bit 3 with two bytes queued
        dq.delete();
        wr0_valid = 1'b1; wr0_data = 8'h11;
        wr1_valid = 1'b1; wr1_data = 8'h22;
        @(negedge sysclk);
        wr0_data = 8'h33; wr1_valid = 1'b0;
        @(negedge sysclk);
        wr0_valid = 1'b0;
        repeat (4 * CLK_DIV + 1) @(negedge sysclk);
        chk("t6_queued", fifo_count, 2);
        chk("t6_bit3_low", uart_tx, 0);
        #1 cpu_resetn = 1'b0;
        #1;
        chk("t6_rst_tx", uart_tx, 1);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rdy", {wr0_ready, wr1_ready}, 3);
        repeat (2) @(negedge sysclk);
        #1 cpu_resetn = 1'b1;
        repeat (20) begin
            @(negedge sysclk);
            chk("t6_stay_idle", uart_tx, 1);
            chk("t6_stay_notbusy", busy, 0);
        end
        wr0_valid = 1'b1; wr0_data = 8'h3C;
        @(negedge sysclk);
        wr0_valid = 1'b0;
        wait_idle(200);
        chk("t6_rx_count", dq.size(), 1);
        if (dq.size() > 0) chk("t6_rx_byte", dq[0], 8'h3C);

        @(negedge sysclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
